grf_wb_arbiter: RTL and testbench
=================================

# grf_wb_arbiter

Shares the single GRF write port between the in-order pipeline write-back stage and one late-result requester, such as the multiply/divide unit or the bus bridge. Late writes are buffered in a small FIFO and are sequenced into cycles where the write-back stage does not write. A starvation counter freezes the pipeline when the buffer waits too long. The block sits between the write-back stage and the GRF, replacing the direct write-back-to-GRF connection.

## Interface
- DEPTH, 4 — FIFO entries for late writes; must be a power of two, at least 2.
- STARVE_LIMIT, 3 — consecutive lost arbitration cycles before a stall is forced; at least 1.
- clk  in  1 — clock.
- reset_n  in  1 — reset, asynchronous, active-low.
- wbEn  in  1 — write-back stage requests a GRF write.
- wbAddr  in  5 — write-back destination register.
- wbData  in  32 — write-back data.
- wbPc  in  32 — write-back PC (for trace).
- secValid  in  1 — late requester offers a write.
- secReady  out  1 — late write accepted on this edge if secValid is also high.
- secAddr / secData / secPc  in  5/32/32 — late write payload.
- grfWe  out  1 — GRF write enable.
- grfWa / grfWd / grfPc  out  5/32/32 — GRF write address, data and PC.
- stallPipe  out  1 — freezes IF through WB pipeline registers.
- pendMask  out  32 — bit n is high while any buffered entry targets register n; used by the hazard unit.

## Operation
- Grant priority:
  - When stallPipe=1, the FIFO head wins.
  - Otherwise, when wbEn=1, the write-back stage wins.
  - Otherwise, when the FIFO is non-empty, the FIFO head wins.
  - Otherwise the port is idle.
- A FIFO grant pops the head on the clock edge.
- Write-back is not registered here: the pipeline holds the MEM/WB register while stallPipe=1, so the same write is presented again on the following cycle.
- Register $0:
  - A granted write with address 0 drives grfWe=0.
  - A FIFO entry addressed to $0 is still popped.
  - A late write addressed to $0 is accepted but never sets pendMask bit 0.
- Push and readiness:
  - secReady = !full, computed from registered state only.
  - A push and a pop in the same cycle are both legal.
  - When full, secReady=0 even if a pop occurs that cycle.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the write-back stage wins.
  - Clears on any pop.
  - Saturates at STARVE_LIMIT.
- stallPipe is a register:
  - Set on the edge where the counter reaches STARVE_LIMIT.
  - Cleared on the edge where the resulting pop occurs.
  - Result: a forced stall is high for exactly one cycle per starvation event.
- pendMask is the OR of one-hot decodes of all valid entries, registered and updated at push and pop. When a push and a pop target the same register and other entries remain, the bit stays set.

## Timing
- Reset (reset_n=0, asynchronous):
  - FIFO empties, counter=0, stallPipe=0, pendMask=0, secReady=1.
  - grfWe is forced to 0 while reset is asserted.
  - Reset mid-operation discards all buffered writes; the late requester must replay them.
- Write-back path: combinational, zero latency. The GRF writes on the same edge the write-back stage presents.
- Late path: accepted on edge N, written at the earliest on the cycle after edge N if the port is free.
- Worst-case late latency: (STARVE_LIMIT+1) × position in FIFO, plus 1 cycle.
- grfWa, grfWd and grfPc read 0 when grfWe=0 and the port is idle.

## Configuration
- GRF_WB_ARB_BYPASS_EN:
  - Defined: when the FIFO is empty, wbEn=0 and stallPipe=0, a valid late write is written to the GRF in the same cycle without entering the FIFO. secReady=1 and pendMask is unaffected.
  - Undefined: every late write passes through the FIFO, with minimum 1-cycle latency.

## Structure
- Package grf_wb_arb_pkg holds:
  - typedef wb_entry_t {addr[4:0], data[31:0], pc[31:0]}.
  - Grant-select enum GNT_NONE/GNT_WB/GNT_SEC.
  - Constant REG_ZERO=5'd0.
- One sub-module, wb_arb_fifo: parameterised circular buffer with read/write pointers one bit wider than the index (full/empty detection on wrap). It exposes head, push, pop, full, empty and the entry array for pendMask.

## Test plan
- Idle pipeline, late write $5=0x1234 accepted at edge 1 → grfWe=1, grfWa=5, grfWd=0x1234 in cycle 2; pendMask[5] is high for one cycle only.
- wbEn held high, 1 late write buffered, STARVE_LIMIT=3 → stallPipe=1 after 3 lost cycles; the FIFO entry is written; the write-back value is written the next cycle and the pipeline resumes.
- Fill 4 entries while wbEn=1 → secReady=0; a fifth offer is held by the requester and accepted only on the edge after the first pop.
- Late write to $0 → grfWe stays 0, entry is popped, pendMask stays 0.
- Reset asserted with 3 entries buffered and stallPipe=1 → all outputs return to their reset values immediately; no buffered write reaches the GRF.
- With GRF_WB_ARB_BYPASS_EN, idle port, late write $7=0xBEEF → grfWe=1 in the same cycle and the FIFO stays empty.

Source files
------------

// File: rtl/grf_wb_arb_pkg.sv
// Shared types for the GRF write-port arbiter: late-write payload, grant select
// and the register-zero constant.
package grf_wb_arb_pkg;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_SEC
    } gnt_sel_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One-hot register decode; $0 never counts as pending.
    function automatic logic [31:0] regDecode(input logic [4:0] a);
        return (a == REG_ZERO) ? 32'd0 : (32'd1 << a);
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// wb_arb_fifo: circular buffer of late GRF writes. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module wb_arb_fifo
    import grf_wb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  wb_entry_t        pushEntry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] liveMask
);
    localparam int IW = $clog2(DEPTH);

    logic [IW:0]   wrPtr;
    logic [IW:0]   rdPtr;
    logic [IW:0]   count;
    logic [IW-1:0] offset;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity comes from the
    // pointers alone, so stale payload is never observed.
    always_ff @(posedge clk) begin
        if (push) entries[wrPtr[IW-1:0]] <= pushEntry;
    end

    assign head  = entries[rdPtr[IW-1:0]];
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[IW] != rdPtr[IW]) && (wrPtr[IW-1:0] == rdPtr[IW-1:0]);

    // Slots still holding a write after this cycle's pop (the head drops out).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        count    = wrPtr - rdPtr;
        offset   = '0;
        liveMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = IW'(i) - rdPtr[IW-1:0];
            liveMask[i] = ({1'b0, offset} < count) && !(pop && (offset == '0));
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between write-back and one buffered
// late requester. Optional same-cycle bypass under macro GRF_WB_ARB_BYPASS_EN.
module grf_wb_arbiter
    import grf_wb_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    input  logic [31:0] wbPc,
    input  logic        secValid,
    output logic        secReady,
    input  logic [4:0]  secAddr,
    input  logic [31:0] secData,
    input  logic [31:0] secPc,
    output logic        grfWe,
    output logic [4:0]  grfWa,
    output logic [31:0] grfWd,
    output logic [31:0] grfPc,
    output logic        stallPipe,
    output logic [31:0] pendMask
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t        wbEntry;
    wb_entry_t        secEntry;
    wb_entry_t        fifoHead;
    wb_entry_t        grantEntry;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] liveMask;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             fifoPush;
    logic             fifoPop;
    logic             bypassTake;
    logic             starveHit;
    gnt_sel_t         gntSel;
    logic [CW-1:0]    starveCnt;
    logic [31:0]      maskNext;

    assign wbEntry  = '{wbAddr, wbData, wbPc};
    assign secEntry = '{secAddr, secData, secPc};

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifoPush),
        .pushEntry(secEntry),
        .pop      (fifoPop),
        .head     (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .entries  (entries),
        .liveMask (liveMask)
    );

    always_comb begin
        bypassTake = 1'b0;
`ifdef GRF_WB_ARB_BYPASS_EN
        bypassTake = fifoEmpty && !wbEn && !stallPipe && secValid;
`endif
        gntSel     = GNT_NONE;
        grantEntry = fifoHead;
        if (stallPipe) begin
            gntSel = GNT_SEC;
        end else if (wbEn) begin
            gntSel     = GNT_WB;
            grantEntry = wbEntry;
        end else if (!fifoEmpty) begin
            gntSel = GNT_SEC;
        end else if (bypassTake) begin
            gntSel     = GNT_SEC;
            grantEntry = secEntry;
        end
    end

    // Readiness looks only at registered fullness, never at this cycle's pop.
    assign secReady  = !fifoFull;
    assign fifoPush  = secValid && !fifoFull && !bypassTake;
    assign fifoPop   = (gntSel == GNT_SEC) && !fifoEmpty;
    assign starveHit = !fifoEmpty && (gntSel == GNT_WB);

    assign grfWe = reset_n && (gntSel != GNT_NONE) && (grantEntry.addr != REG_ZERO);
    assign grfWa = grfWe ? grantEntry.addr : '0;
    assign grfWd = grfWe ? grantEntry.data : '0;
    assign grfPc = grfWe ? grantEntry.pc   : '0;

    always_comb begin
        maskNext = fifoPush ? regDecode(secAddr) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (liveMask[i]) maskNext = maskNext | regDecode(entries[i].addr);
        end
    end

    // The stall rises as the counter reaches the limit and falls with the pop it forces.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starveCnt <= '0;
            stallPipe <= 1'b0;
            pendMask  <= '0;
        end else begin
            if (fifoPop) begin
                starveCnt <= '0;
                stallPipe <= 1'b0;
            end else if (starveHit && (starveCnt != CW'(STARVE_LIMIT))) begin
                starveCnt <= starveCnt + 1'b1;
                if (starveCnt == CW'(STARVE_LIMIT - 1)) stallPipe <= 1'b1;
            end
            pendMask <= maskNext;
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: a queue-based reference model predicts each
// cycle's port outputs; a monitor process compares them against the DUT.
module tb_grf_wb_arbiter;
    import grf_wb_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wbEn = 1'b0;
    logic [4:0]  wbAddr = '0;
    logic [31:0] wbData = '0;
    logic [31:0] wbPc = '0;
    logic        secValid = 1'b0;
    logic        secReady;
    logic [4:0]  secAddr = '0;
    logic [31:0] secData = '0;
    logic [31:0] secPc = '0;
    logic        grfWe;
    logic [4:0]  grfWa;
    logic [31:0] grfWd;
    logic [31:0] grfPc;
    logic        stallPipe;
    logic [31:0] pendMask;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData), .wbPc(wbPc),
        .secValid(secValid), .secReady(secReady),
        .secAddr(secAddr), .secData(secData), .secPc(secPc),
        .grfWe(grfWe), .grfWa(grfWa), .grfWd(grfWd), .grfPc(grfPc),
        .stallPipe(stallPipe), .pendMask(pendMask)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        stall;
        logic        ready;
        logic [31:0] pend;
    } exp_t;

    exp_t      expQ[$];
    wb_entry_t mQ[$];
    int        mCnt = 0;
    bit        mStall = 0;
    bit        holdWb = 0;
    bit        lastEn = 0;
    wb_entry_t lastWb = '0;
    bit        offValid = 0;
    wb_entry_t offEnt = '0;
    int        total = 0;
    int        bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic wb_entry_t mk(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        wb_entry_t e;
        e.addr = a; e.data = d; e.pc = p;
        return e;
    endfunction

    function automatic logic [31:0] modelPend();
        logic [31:0] m = '0;
        foreach (mQ[i]) if (mQ[i].addr != 0) m[mQ[i].addr] = 1'b1;
        return m;
    endfunction

    task automatic offer(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        offValid = 1;
        offEnt   = mk(a, d, p);
    endtask

    // One clock: drive inputs at the falling edge, predict outputs, advance the model.
    task automatic cycle(input bit rst, input bit en, input wb_entry_t w);
        exp_t      e;
        wb_entry_t g = '0;
        bit        gnt = 0, pop = 0, ready, byp = 0;
        @(negedge clk);
        if (!rst) begin
            mQ.delete(); mCnt = 0; mStall = 0; holdWb = 0;
        end
        if (holdWb) begin en = lastEn; w = lastWb; end
        lastEn = en; lastWb = w;
        holdWb = mStall;
        reset_n = rst;
        wbEn = en; wbAddr = w.addr; wbData = w.data; wbPc = w.pc;
        secValid = offValid; secAddr = offEnt.addr; secData = offEnt.data; secPc = offEnt.pc;
        ready = (mQ.size() < DEPTH);
`ifdef GRF_WB_ARB_BYPASS_EN
        byp = rst && (mQ.size() == 0) && !en && !mStall && offValid;
`endif
        if (rst) begin
            if (mStall)               begin g = mQ[0]; gnt = 1; pop = 1; end
            else if (en)              begin g = w;     gnt = 1; end
            else if (mQ.size() > 0)   begin g = mQ[0]; gnt = 1; pop = 1; end
            else if (byp)             begin g = offEnt; gnt = 1; end
        end
        e.we    = gnt && (g.addr != 0);
        e.wa    = e.we ? g.addr : 5'd0;
        e.wd    = e.we ? g.data : 32'd0;
        e.pc    = e.we ? g.pc : 32'd0;
        e.stall = mStall;
        e.ready = ready;
        e.pend  = modelPend();
        expQ.push_back(e);
        if (rst) begin
            if (pop) begin
                void'(mQ.pop_front());
                mCnt = 0; mStall = 0;
            end else if (en && mQ.size() > 0) begin
                if (mCnt < LIMIT) mCnt++;
                if (mCnt == LIMIT) mStall = 1;
            end
            if (offValid && (byp || ready)) begin
                if (!byp) mQ.push_back(offEnt);
                offValid = 0;
            end
        end
    endtask

    task automatic waitAccept(input bit en, input string name);
        int n = 0;
        while (offValid && n < 40) begin
            cycle(1, en, mk(5'($urandom_range(1, 31)), $urandom, $urandom));
            n++;
        end
        if (offValid) begin
            bad++;
            $display("FAIL %s actual=still_offered required=accepted", name);
            offValid = 0;
        end
    endtask

    // Reset lands mid-cycle while entries are buffered and the stall is high.
    task automatic asyncResetCheck();
        @(negedge clk);
        #5;
        check("pre_rst_stall", stallPipe, mStall);
        check("pre_rst_pend", pendMask, modelPend());
        reset_n = 1'b0;
        wbEn = 1'b1; wbAddr = 5'd9; wbData = 32'hDEAD_0009;
        #1;
        check("rst_grfWe", grfWe, 1'b0);
        check("rst_grfWa", grfWa, 5'd0);
        check("rst_stall", stallPipe, 1'b0);
        check("rst_pend", pendMask, 32'd0);
        check("rst_ready", secReady, 1'b1);
        mQ.delete(); mCnt = 0; mStall = 0; holdWb = 0; lastEn = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("grfWe", grfWe, e.we);
                check("grfWa", grfWa, e.wa);
                check("grfWd", grfWd, e.wd);
                check("grfPc", grfPc, e.pc);
                check("stallPipe", stallPipe, e.stall);
                check("secReady", secReady, e.ready);
                check("pendMask", pendMask, e.pend);
            end
        end
    end

    initial begin : stimulus
        wb_entry_t idle;
        idle = '0;
        repeat (2) cycle(0, 0, idle);

        // Idle pipeline, single late write to $5.
        offer(5'd5, 32'h1234, 32'h100);
        cycle(1, 0, idle);
        repeat (3) cycle(1, 0, idle);

        // Continuous write-back starves one buffered entry until the forced stall.
        offer(5'd9, 32'hA5A5_0009, 32'h200);
        cycle(1, 1, mk(5'd3, 32'h3000_0000, 32'h300));
        for (int k = 1; k <= 6; k++) cycle(1, 1, mk(5'd3, 32'h3000_0000 + k, 32'h300 + 4 * k));
        repeat (2) cycle(1, 0, idle);

        // Fill the buffer under write-back pressure; the fifth offer must wait.
        for (int k = 0; k < 5; k++) begin
            offer(5'(10 + k), 32'hF000_0000 + k, 32'h400 + 4 * k);
            waitAccept(1, "fill_accept");
        end
        repeat (8) cycle(1, 0, idle);

        // Late write to $0 is popped but never written or marked pending.
        offer(5'd0, 32'h5555_5555, 32'h500);
        cycle(1, 0, idle);
        repeat (3) cycle(1, 0, idle);

        // Three buffered entries with the stall raised, then asynchronous reset.
        for (int k = 0; k < 3; k++) begin
            offer(5'(20 + k), 32'hC000_0000 + k, 32'h600 + 4 * k);
            cycle(1, 1, mk(5'd4, 32'h4000_0000 + k, 32'h700 + 4 * k));
        end
        cycle(1, 1, mk(5'd4, 32'h4000_0010, 32'h740));
        asyncResetCheck();
        cycle(0, 1, mk(5'd4, 32'h4000_0020, 32'h780));
        repeat (4) cycle(1, 0, idle);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                offValid = 0;
                cycle(0, 0, idle);
            end else begin
                if (!offValid && $urandom_range(0, 2) != 0)
                    offer(5'($urandom_range(0, 31)), $urandom, $urandom);
                cycle(1, $urandom_range(0, 99) < 60, mk(5'($urandom_range(0, 31)), $urandom, $urandom));
            end
        end
        offValid = 0;
        repeat (12) cycle(1, 0, idle);
        repeat (2) @(negedge clk);
        #5;
        check("scoreboard_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
